icache: RTL

- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's instruction port.
- Converts IF fetch requests into single-cycle hits, or word refills over a req/ok handshake with the memory controller.
- Supports flush on taken branch, where an outstanding refill still completes but its response is dropped.
- Freezes fully while rdy_in is low.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_if.sv | 28 ++
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 124 ++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: state encoding, default
// geometry and the IO address-space test used alongside the memory controller.
package icache_pkg;

    localparam int unsigned IndexWDefault = 6;
    localparam int unsigned AddrWDefault  = 18;
    localparam int unsigned TagWDefault   = AddrWDefault - IndexWDefault - 2;

    typedef enum logic [1:0] {
        IcIdle = 2'd0,
        IcMiss = 2'd1,
        IcDrop = 2'd2
    } ic_state_e;

    // Addresses with bits 17:16 set map to IO space and must never be cached.
    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;

    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        busy_o;
    logic        inst_ok_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ok_i;
    logic [31:0] mem_data_i;

    // The cache itself.
    modport slave (
        input  fetch_req_i, pc_i, flush_i, mem_ok_i, mem_data_i,
        output busy_o, inst_ok_o, inst_o, inst_pc_o, mem_req_o, mem_addr_o
    );

    // The IF stage plus memory controller driving the cache.
    modport master (
        output fetch_req_i, pc_i, flush_i, mem_ok_i, mem_data_i,
        input  busy_o, inst_ok_o, inst_o, inst_pc_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data with combinational read and one
// synchronous write port. Clearing drops every valid bit in a single cycle.
module icache_array #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 10
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [31:0]        wr_data_i
);

    localparam int unsigned Lines = 1 << INDEX_W;

    logic [Lines-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    // Valid bits: cleared together on clear, set on line write.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer the next
// cycle; misses refill one word over req/ok. A flush during a refill lets the
// refill finish (the memory controller cannot abort) but discards its answer.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = IndexWDefault,
    parameter int unsigned ADDR_W  = AddrWDefault
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    icache_if.slave  bus
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

    ic_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] resp_pc_q, resp_pc_d;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_data;
    logic               fill;
    logic               wr_en;
    logic               hit;

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk_i      (clk_in),
        .clear_i    (rst_in),
        .rd_idx_i   (bus.pc_i[INDEX_W+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pc_q[INDEX_W+1:2]),
        .wr_tag_i   (pc_q[ADDR_W-1:INDEX_W+2]),
        .wr_data_i  (bus.mem_data_i)
    );

    // IO addresses always take the refill path so they are never served stale.
    assign hit   = rd_valid && (rd_tag == bus.pc_i[ADDR_W-1:INDEX_W+2])
                   && !is_io_addr(bus.pc_i);
    assign wr_en = fill && !rst_in && !is_io_addr(pc_q);

    // Next state, latched pc and pending response; everything holds while rdy is low.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_pc_d    = resp_pc_q;
        fill         = 1'b0;
        if (rdy_in) begin
            // A pending pulse is presented this cycle, so it retires here.
            resp_valid_d = 1'b0;
            unique case (state_q)
                IcIdle: begin
                    if (!bus.flush_i && bus.fetch_req_i) begin
                        if (hit) begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = rd_data;
                            resp_pc_d    = bus.pc_i;
                        end else begin
                            state_d = IcMiss;
                            pc_d    = bus.pc_i;
                        end
                    end
                end
                IcMiss: begin
                    if (bus.mem_ok_i) begin
                        fill    = 1'b1;
                        state_d = IcIdle;
                        if (!bus.flush_i) begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = bus.mem_data_i;
                            resp_pc_d    = pc_q;
                        end
                    end else if (bus.flush_i) begin
                        state_d = IcDrop;
                    end
                end
                IcDrop: begin
                    if (bus.mem_ok_i) begin
                        fill    = 1'b1;
                        state_d = IcIdle;
                    end
                end
                default: state_d = IcIdle;
            endcase
        end
    end

    // State register with synchronous reset; reset abandons any refill.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IcIdle;
            pc_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

    assign bus.busy_o     = (state_q != IcIdle);
    assign bus.mem_req_o  = (state_q == IcMiss) || (state_q == IcDrop);
    assign bus.mem_addr_o = {pc_q[31:2], 2'b00};
    assign bus.inst_ok_o  = resp_valid_q && rdy_in;
    assign bus.inst_o     = resp_data_q;
    assign bus.inst_pc_o  = resp_pc_q;

endmodule
